// File: rtl/riscv_defines.sv
// Shared definitions for the RISC-V interrupt arbiter: config register map and FSM states.
package riscv_defines;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CLEAR   = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set bit of the eligible vector.
module riscv_irq_prio_enc #(
  parameter int N_IRQ = 32,
  parameter int ID_W  = 5
) (
  input  logic [N_IRQ-1:0] eligible,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id    = '0;
    valid = |eligible;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      id = eligible[i] ? ID_W'(i) : id;
    end
  end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Edge-triggered interrupt arbiter: pending/mask registers, fixed priority,
// and a request/ack handshake toward the core with a mandatory gap cycle.
module riscv_irq_arbiter
  import riscv_defines::*;
#(
  parameter int N_IRQ = 32,
  parameter int ID_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] irq_src_i,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             irq_ack_i,
  input  logic [ID_W-1:0]  irq_ack_id_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [31:0]      cfg_wdata_i,
  output logic [31:0]      cfg_rdata_o
);

  logic [N_IRQ-1:0] src_q_r;
  logic [N_IRQ-1:0] src_prev_r;
  logic [N_IRQ-1:0] pending_r;
  logic [N_IRQ-1:0] mask_r;
  irq_state_e       state_r;
  logic             irq_r;
  logic [ID_W-1:0]  irq_id_r;

  logic [N_IRQ-1:0] set_s;
  logic [N_IRQ-1:0] clr_s;
  logic [N_IRQ-1:0] sel_s;
  logic [N_IRQ-1:0] eligible_s;
  logic             win_valid_s;
  logic [ID_W-1:0]  win_id_s;
  logic             withdraw_s;

  assign eligible_s = pending_r & mask_r;
  assign irq_o      = irq_r;
  assign irq_id_o   = irq_id_r;

  riscv_irq_prio_enc #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .eligible (eligible_s),
    .valid    (win_valid_s),
    .id       (win_id_s)
  );

  // Pending set/clear sources and the one-hot select of the presented ID.
  always_comb begin
    set_s = (src_q_r & ~src_prev_r)
          | ((cfg_we_i && (cfg_addr_i == ADDR_PENDING)) ? cfg_wdata_i[N_IRQ-1:0] : '0);
    clr_s = (cfg_we_i && (cfg_addr_i == ADDR_CLEAR)) ? cfg_wdata_i[N_IRQ-1:0] : '0;
    sel_s = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr_s[i] = clr_s[i] | (irq_ack_i && (irq_ack_id_i == ID_W'(i)));
      sel_s[i] = (irq_id_r == ID_W'(i));
    end
    withdraw_s = ~|(sel_s & eligible_s);
  end

  // Combinational config read mux; unused bits read zero.
  always_comb begin
    cfg_rdata_o = 32'h0000_0000;
    case (cfg_addr_i)
      ADDR_MASK:    cfg_rdata_o[N_IRQ-1:0] = mask_r;
      ADDR_PENDING: cfg_rdata_o[N_IRQ-1:0] = pending_r;
      ADDR_CLEAR:   cfg_rdata_o = 32'h0000_0000;
      ADDR_STATUS: begin
        cfg_rdata_o[31]       = irq_r;
        cfg_rdata_o[ID_W-1:0] = irq_id_r;
      end
      default:      cfg_rdata_o = 32'h0000_0000;
    endcase
  end

  // Source sampling, edge detection, pending (set wins over clear) and mask.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q_r    <= '0;
      src_prev_r <= '0;
      pending_r  <= '0;
      mask_r     <= '0;
    end else begin
      src_q_r    <= irq_src_i;
      src_prev_r <= src_q_r;
      pending_r  <= (pending_r & ~clr_s) | set_s;
      if (cfg_we_i && (cfg_addr_i == ADDR_MASK)) begin
        mask_r <= cfg_wdata_i[N_IRQ-1:0];
      end
    end
  end

  // Handshake FSM; a presented ID is never preempted, only acked or withdrawn.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      irq_r    <= 1'b0;
      irq_id_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_valid_s) begin
            state_r  <= ST_REQ;
            irq_r    <= 1'b1;
            irq_id_r <= win_id_s;
          end
        end
        ST_REQ: begin
          if (irq_ack_i || withdraw_s) begin
            state_r <= ST_GAP;
            irq_r   <= 1'b0;
          end
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
          irq_r   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          irq_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Self-checking bench for riscv_irq_arbiter: presented IDs are checked against a
// scoreboard queue, register and handshake timing by direct comparisons.
module tb_riscv_irq_arbiter;

  localparam int N_IRQ = 32;
  localparam int ID_W  = 5;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [N_IRQ-1:0] irq_src_i;
  logic             irq_o;
  logic [ID_W-1:0]  irq_id_o;
  logic             irq_ack_i;
  logic [ID_W-1:0]  irq_ack_id_i;
  logic             cfg_we_i;
  logic [1:0]       cfg_addr_i;
  logic [31:0]      cfg_wdata_i;
  logic [31:0]      cfg_rdata_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ID_W-1:0] exp_q[$];
  logic irq_seen = 1'b0;
  logic [31:0] rd;

  riscv_irq_arbiter #(.N_IRQ(N_IRQ), .ID_W(ID_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .irq_src_i    (irq_src_i),
    .irq_o        (irq_o),
    .irq_id_o     (irq_id_o),
    .irq_ack_i    (irq_ack_i),
    .irq_ack_id_i (irq_ack_id_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_rdata_o  (cfg_rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic cfg_wr(input logic [1:0] addr, input logic [31:0] data);
    cfg_we_i    = 1'b1;
    cfg_addr_i  = addr;
    cfg_wdata_i = data;
    cyc(1);
    cfg_we_i    = 1'b0;
  endtask

  task automatic cfg_rd(input logic [1:0] addr, output logic [31:0] data);
    cfg_addr_i = addr;
    #1;
    data = cfg_rdata_o;
  endtask

  task automatic pulse_src(input logic [N_IRQ-1:0] bits);
    irq_src_i = bits;
    cyc(1);
    irq_src_i = '0;
  endtask

  task automatic ack(input logic [ID_W-1:0] id);
    irq_ack_i    = 1'b1;
    irq_ack_id_i = id;
    cyc(1);
    irq_ack_i    = 1'b0;
  endtask

  task automatic wait_irq(input string tag);
    int k;
    k = 0;
    while (!irq_o && k < 20) begin
      cyc(1);
      k++;
    end
    check_val({tag, "_irq_timeout"}, {31'd0, irq_o}, 32'd1);
  endtask

  // Scoreboard monitor: each new presentation pops the next expected ID.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (irq_o && !irq_seen) begin
        if (exp_q.size() == 0) begin
          check_val("sb_unexpected_irq", {27'd0, irq_id_o}, 32'hFFFF_FFFF);
        end else begin
          check_val("sb_irq_id", {27'd0, irq_id_o}, {27'd0, exp_q.pop_front()});
        end
      end
      irq_seen = irq_o;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; irq_src_i = '0; irq_ack_i = 1'b0; irq_ack_id_i = '0;
    cfg_we_i = 1'b0; cfg_addr_i = 2'd0; cfg_wdata_i = 32'd0;
    cyc(3);
    rst_ni = 1'b1;
    check_val("rst_irq", {31'd0, irq_o}, 32'd0);
    check_val("rst_id", {27'd0, irq_id_o}, 32'd0);
    cfg_rd(2'd0, rd); check_val("rst_mask", rd, 32'd0);
    cfg_rd(2'd1, rd); check_val("rst_pending", rd, 32'd0);
    cfg_rd(2'd3, rd); check_val("rst_status", rd, 32'd0);

    // Single source, exact latency, ack clears pending
    cfg_wr(2'd0, 32'h0000_0001);
    exp_q.push_back(5'd0);
    pulse_src(32'h0000_0001);
    check_val("lat_n", {31'd0, irq_o}, 32'd0);
    cyc(1);
    check_val("lat_n1", {31'd0, irq_o}, 32'd0);
    cfg_rd(2'd1, rd); check_val("lat_pending", rd, 32'h0000_0001);
    cyc(1);
    check_val("lat_n2_irq", {31'd0, irq_o}, 32'd1);
    check_val("lat_n2_id", {27'd0, irq_id_o}, 32'd0);
    ack(5'd0);
    check_val("ack0_irq", {31'd0, irq_o}, 32'd0);
    cfg_rd(2'd1, rd); check_val("ack0_pending", rd, 32'd0);
    cyc(2);

    // Two simultaneous sources: lowest ID first, gap, then the other
    cfg_wr(2'd0, 32'hFFFF_FFFF);
    exp_q.push_back(5'd3); exp_q.push_back(5'd7);
    pulse_src(32'h0000_0088);
    wait_irq("prio3");
    check_val("prio_first", {27'd0, irq_id_o}, 32'd3);
    ack(5'd3);
    check_val("prio_gap", {31'd0, irq_o}, 32'd0);
    cyc(2);
    check_val("prio_second_irq", {31'd0, irq_o}, 32'd1);
    check_val("prio_second", {27'd0, irq_id_o}, 32'd7);
    ack(5'd7);
    cyc(2);

    // No preemption by a higher-priority source
    exp_q.push_back(5'd5); exp_q.push_back(5'd1);
    pulse_src(32'h0000_0020);
    wait_irq("np5");
    pulse_src(32'h0000_0002);
    cyc(4);
    check_val("np_hold_id", {27'd0, irq_id_o}, 32'd5);
    check_val("np_hold_irq", {31'd0, irq_o}, 32'd1);
    cfg_rd(2'd3, rd); check_val("np_status", rd, 32'h8000_0005);
    cfg_rd(2'd2, rd); check_val("clear_reads0", rd, 32'd0);
    ack(5'd5);
    wait_irq("np1");
    check_val("np_then1", {27'd0, irq_id_o}, 32'd1);
    ack(5'd1);
    cyc(2);

    // Withdraw via CLEAR, then via MASK
    exp_q.push_back(5'd4);
    pulse_src(32'h0000_0010);
    wait_irq("wd_clr");
    cfg_wr(2'd2, 32'h0000_0010);
    cyc(1);
    check_val("wd_clear_irq", {31'd0, irq_o}, 32'd0);
    cfg_rd(2'd1, rd); check_val("wd_clear_pending", rd, 32'd0);
    cyc(2);
    exp_q.push_back(5'd4);
    pulse_src(32'h0000_0010);
    wait_irq("wd_mask");
    cfg_wr(2'd0, 32'hFFFF_FFEF);
    cyc(1);
    check_val("wd_mask_irq", {31'd0, irq_o}, 32'd0);
    cyc(3);
    check_val("wd_mask_stays_low", {31'd0, irq_o}, 32'd0);
    cfg_rd(2'd1, rd); check_val("wd_mask_pending", rd, 32'h0000_0010);
    cfg_wr(2'd2, 32'h0000_0010);
    cfg_wr(2'd0, 32'hFFFF_FFFF);
    cyc(2);

    // Ack and new edge of the same source in one cycle: set wins
    exp_q.push_back(5'd2); exp_q.push_back(5'd2);
    pulse_src(32'h0000_0004);
    wait_irq("sw_first");
    pulse_src(32'h0000_0004);
    ack(5'd2);
    check_val("sw_gap", {31'd0, irq_o}, 32'd0);
    cfg_rd(2'd1, rd); check_val("sw_pending", rd, 32'h0000_0004);
    wait_irq("sw_again");
    check_val("sw_id", {27'd0, irq_id_o}, 32'd2);
    ack(5'd2);
    cyc(2);

    // Reset while presenting with several pending bits
    exp_q.push_back(5'd0);
    cfg_wr(2'd1, 32'h0000_00FF);
    wait_irq("rst_req");
    cfg_rd(2'd1, rd); check_val("pre_rst_pending", rd, 32'h0000_00FF);
    rst_ni = 1'b0;
    cyc(1);
    rst_ni = 1'b1;
    check_val("rst_req_irq", {31'd0, irq_o}, 32'd0);
    cfg_rd(2'd1, rd); check_val("rst_req_pending", rd, 32'd0);
    cfg_rd(2'd0, rd); check_val("rst_req_mask", rd, 32'd0);
    cyc(3);
    check_val("post_rst_idle", {31'd0, irq_o}, 32'd0);
    check_val("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
